// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered successor to the combinational ALU.
// One operation in flight at a time; MUL is an iterative shift-add that
// takes WIDTH+1 cycles, every other opcode completes in one cycle.
//
// Build option: define ALU_SEQ_MUL_EN to enable the iterative multiply.
// When undefined, opcode 110 completes in one cycle with result 0,
// zero 1 and err 1, and the BUSY state, accumulator and counter are absent.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready is registered)
//   a, b, alu_control   operands and 3-bit opcode, sampled on accept only
//   out_valid/out_ready result handshake
//   result              registered WIDTH-bit result
//   zero, overflow,     registered status flags, held with result
//   carry, negative,
//   err                 illegal/unsupported opcode flag
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             negative,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned AW    = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_e;
`endif

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             carry_q, carry_d;
  logic             negative_q, negative_d;
  logic             err_q, err_d;

`ifdef ALU_SEQ_MUL_EN
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_step;
  logic             mul_last;
`endif

  logic             accept;
  logic             is_mul;

  // Single-cycle ALU, evaluated straight from the input ports on accept
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [CNT_W-1:0] sh_amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_c;
  logic             alu_e;

  assign accept = in_valid && in_ready_q && (state_q == IDLE);
  assign is_mul = (alu_control == OP_MUL);

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    // MSB of the widened difference is the borrow, so carry is its inverse
    sub_w   = {1'b0, a} - {1'b0, b};
    sh_amt  = b[CNT_W-1:0];
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_e   = 1'b0;
    case (alu_control)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = ~sub_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_XOR: alu_res = a ^ b;
      OP_OR:  alu_res = a | b;
      // True signed compare, immune to subtraction overflow
      OP_SLT: alu_res = WIDTH'($signed(a) < $signed(b));
      OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
        alu_e = 1'b1;
`endif
      end
      OP_SLL: alu_res = (32'(sh_amt) >= WIDTH) ? '0 : (a << sh_amt);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // One LSB-first shift-add step of the multiplier
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          state_d = is_mul ? BUSY : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        if (mul_last) state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless updated
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    carry_d     = carry_q;
    negative_d  = negative_q;
    err_d       = err_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (is_mul) begin
            mcand_d  = AW'(a);
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_v;
            carry_d    = alu_c;
            negative_d = alu_res[WIDTH-1];
            err_d      = alu_e;
          end
`else
          result_d   = alu_res;
          zero_d     = (alu_res == '0);
          overflow_d = alu_v;
          carry_d    = alu_c;
          negative_d = alu_res[WIDTH-1];
          err_d      = alu_e;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Final step lands directly in the result registers
        if (mul_last) begin
          result_d   = acc_step[WIDTH-1:0];
          zero_d     = (acc_step[WIDTH-1:0] == '0);
          overflow_d = |acc_step[AW-1:WIDTH];
          carry_d    = 1'b0;
          negative_d = acc_step[WIDTH-1];
          err_d      = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
      negative_q  <= negative_d;
      err_q       <= err_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry     = carry_q;
  assign negative  = negative_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq at WIDTH=4: directed cases plus randomized
// operations against an arithmetic reference model. Follows the
// ALU_SEQ_MUL_EN build option for MUL expectations.
module tb_alu_seq;

  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         carry;
  logic         negative;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] obs_res;
  logic [4:0]   obs_flags;
  int           obs_lat;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .carry       (carry),
    .negative    (negative),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {err, zero, overflow, carry, negative, result}
  function automatic logic [W+4:0] ref_model(input int op, input int av, input int bv);
    int m;
    int half;
    int sa;
    int sb;
    int full;
    int r;
    int sh;
    bit e;
    bit v;
    bit c;
    m    = 1 << W;
    half = m / 2;
    sa   = (av >= half) ? av - m : av;
    sb   = (bv >= half) ? bv - m : bv;
    r = 0; e = 0; v = 0; c = 0;
    case (op)
      0: begin
        full = av + bv;
        r = full % m;
        c = (full >= m);
        v = (sa + sb > half - 1) || (sa + sb < -half);
      end
      1: begin
        r = (av - bv + m) % m;
        c = (av >= bv);
        v = (sa - sb > half - 1) || (sa - sb < -half);
      end
      2: r = av & bv;
      3: r = av ^ bv;
      4: r = av | bv;
      5: r = (sa < sb) ? 1 : 0;
      6: begin
`ifdef ALU_SEQ_MUL_EN
        full = av * bv;
        r = full % m;
        v = (full >= m);
`else
        r = 0;
        e = 1;
`endif
      end
      default: begin
        sh = bv % (1 << CNT_W);
        r  = (sh >= W) ? 0 : ((av << sh) % m);
      end
    endcase
    return {e, (r == 0), v, c, (r >= half), W'(r)};
  endfunction

  // Issue one operation, check it against the model, hold for stall cycles, consume
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int stall);
    int guard;
    int lat;
    int exp_lat;
    bit busy_ok;
    logic [W+4:0] exp_v;
    logic [W+4:0] held;
    exp_v = ref_model(int'(op), int'(av), int'(bv));
`ifdef ALU_SEQ_MUL_EN
    exp_lat = (op == 3'd6) ? W + 1 : 1;
`else
    exp_lat = 1;
`endif
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid    = 1'b1;
    alu_control = op;
    a           = av;
    b           = bv;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    a           = W'($urandom);
    b           = W'($urandom);
    alu_control = 3'($urandom);
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    obs_lat   = lat;
    obs_res   = result;
    obs_flags = {err, zero, overflow, carry, negative};
    check("latency", 64'(lat), 64'(exp_lat));
    check("in_ready_busy", 64'(busy_ok), 64'd1);
    check("result", 64'(obs_res), 64'(exp_v[W-1:0]));
    check("flags", 64'(obs_flags), 64'(exp_v[W+4:W]));
    held = {obs_flags, obs_res};
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold", 64'({out_valid, in_ready, err, zero, overflow, carry, negative, result}),
            64'({2'b10, held}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    alu_control = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs",
          64'({in_ready, out_valid, err, zero, overflow, carry, negative, result}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 64'({in_ready, out_valid}), 64'(2'b10));

    // ADD 7+1: signed overflow into the sign bit, no carry
    do_op(3'd0, 4'd7, 4'd1, 0);
    check("add71_res", 64'(obs_res), 64'd8);
    check("add71_flags", 64'(obs_flags), 64'(5'b00101));
    check("add71_lat", 64'(obs_lat), 64'd1);

    // SUB 5-5: zero result, no borrow
    do_op(3'd1, 4'd5, 4'd5, 0);
    check("sub55_res", 64'(obs_res), 64'd0);
    check("sub55_flags", 64'(obs_flags), 64'(5'b01010));

    // SLT -8 < 1
    do_op(3'd5, 4'd8, 4'd1, 0);
    check("slt_res", 64'(obs_res), 64'd1);
    check("slt_flags", 64'(obs_flags), 64'd0);

`ifdef ALU_SEQ_MUL_EN
    do_op(3'd6, 4'd3, 4'd5, 1);
    check("mul35_res", 64'(obs_res), 64'd15);
    check("mul35_flags", 64'(obs_flags), 64'(5'b00001));
    check("mul35_lat", 64'(obs_lat), 64'(W + 1));
    do_op(3'd6, 4'd4, 4'd4, 0);
    check("mul44_res", 64'(obs_res), 64'd0);
    check("mul44_flags", 64'(obs_flags), 64'(5'b01100));
`else
    do_op(3'd6, 4'd3, 4'd3, 0);
    check("mul_off_res", 64'(obs_res), 64'd0);
    check("mul_off_flags", 64'(obs_flags), 64'(5'b11000));
    check("mul_off_lat", 64'(obs_lat), 64'd1);
`endif

    // SLL by 5 on a 4-bit datapath shifts everything out
    do_op(3'd7, 4'd1, 4'd5, 0);
    check("sll15_res", 64'(obs_res), 64'd0);
    check("sll15_flags", 64'(obs_flags), 64'(5'b01000));

    // Backpressure: result held for 3 cycles
    do_op(3'd0, 4'd2, 4'd3, 3);
    check("bp_res", 64'(obs_res), 64'd5);

    // Reset two cycles into a MUL (or its DONE phase when MUL is disabled)
    in_valid    = 1'b1;
    alu_control = 3'd6;
    a           = 4'd3;
    b           = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs",
          64'({in_ready, out_valid, err, zero, overflow, carry, negative, result}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    do_op(3'd2, 4'd12, 4'd10, 0);
    check("and_after_rst", 64'(obs_res), 64'd8);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
